loop_stepdown_seq: RTL and testbench



---
 rtl/loop_stepdown_seq.sv | 153 +++++++++++++++
 tb/tb_loop_stepdown_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/loop_stepdown_seq.sv
// Step-down converter switch sequencer: dead-time PWM, soft-start duty ramp,
// zero-crossing low-side cutoff and timed overcurrent lockout.
module loop_stepdown_seq #(
    parameter int unsigned DT         = 4,
    parameter int unsigned SS_DIV     = 4,
    parameter int unsigned FAULT_HOLD = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       CELV,
    input  logic       CELG,
    input  logic       SUB,
    input  logic       en,
    input  logic [7:0] duty,
    input  logic       ocp,
    input  logic       zcd,
    output logic       hs_on,
    output logic       ls_on,
    output logic       ss_done,
    output logic       fault
);

    typedef enum logic [1:0] {IDLE, SOFTSTART, RUN, FAULT} state_t;

    localparam logic [7:0]  DT8       = 8'(DT);
    localparam logic [8:0]  DT9       = 9'(DT);
    localparam logic [7:0]  SS_LAST   = 8'(SS_DIV - 1);
    localparam logic [15:0] HOLD_INIT = 16'(FAULT_HOLD);

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [7:0]  d_eff, d_eff_nxt;
    logic [7:0]  div, div_nxt;
    logic [15:0] hold, hold_nxt;
    logic        zflag, zflag_nxt;
    logic        hs_nxt, ls_nxt, ss_nxt, fault_nxt;
    logic [7:0]  d_step;
    logic        boundary;
    logic        rails_unused;

    assign rails_unused = CELV ^ CELG ^ SUB;
    assign boundary     = (cnt == 8'hFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            d_eff   <= '0;
            div     <= '0;
            hold    <= '0;
            zflag   <= 1'b0;
            hs_on   <= 1'b0;
            ls_on   <= 1'b0;
            ss_done <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            d_eff   <= d_eff_nxt;
            div     <= div_nxt;
            hold    <= hold_nxt;
            zflag   <= zflag_nxt;
            hs_on   <= hs_nxt;
            ls_on   <= ls_nxt;
            ss_done <= ss_nxt;
            fault   <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        d_eff_nxt = d_eff;
        div_nxt   = div;
        hold_nxt  = hold;
        zflag_nxt = zflag;
        hs_nxt    = 1'b0;
        ls_nxt    = 1'b0;
        ss_nxt    = ss_done;
        fault_nxt = fault;
        d_step    = (d_eff < duty) ? d_eff + 8'd1 : duty;

        case (state)
            IDLE: begin
                cnt_nxt   = '0;
                ss_nxt    = 1'b0;
                fault_nxt = 1'b0;
                if (en && !ocp) begin
                    state_nxt = SOFTSTART;
                    d_eff_nxt = '0;
                    div_nxt   = '0;
                    zflag_nxt = 1'b0;
                end
            end
            SOFTSTART, RUN: begin
                if (ocp) begin
                    state_nxt = FAULT;
                    cnt_nxt   = '0;
                    hold_nxt  = HOLD_INIT;
                    fault_nxt = 1'b1;
                    ss_nxt    = 1'b0;
                    zflag_nxt = 1'b0;
                end else if (!en) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    ss_nxt    = 1'b0;
                    zflag_nxt = 1'b0;
                end else begin
                    cnt_nxt   = cnt + 8'd1;
                    hs_nxt    = (cnt >= DT8) && (cnt < d_eff);
                    // 9-bit compare so d_eff+DT past 255 suppresses the low side
                    ls_nxt    = ({1'b0, cnt} >= ({1'b0, d_eff} + DT9)) && !zflag && !zcd;
                    zflag_nxt = zflag | zcd;
                    if (boundary) begin
                        zflag_nxt = 1'b0;
                        if (state == RUN) begin
                            d_eff_nxt = duty;
                        end else if (div == SS_LAST) begin
                            div_nxt   = '0;
                            d_eff_nxt = d_step;
                            if (d_step == duty) begin
                                state_nxt = RUN;
                                ss_nxt    = 1'b1;
                            end
                        end else begin
                            div_nxt = div + 8'd1;
                        end
                    end
                end
            end
            FAULT: begin
                cnt_nxt = '0;
                // hold==1 here means it reaches 0 on this edge: lockout lasts FAULT_HOLD cycles
                if (hold <= 16'd1) begin
                    if (ocp) begin
                        hold_nxt = HOLD_INIT;
                    end else begin
                        hold_nxt  = '0;
                        fault_nxt = 1'b0;
                        d_eff_nxt = '0;
                        div_nxt   = '0;
                        zflag_nxt = 1'b0;
                        state_nxt = en ? SOFTSTART : IDLE;
                    end
                end else begin
                    hold_nxt = hold - 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_loop_stepdown_seq.sv
// Directed bench for loop_stepdown_seq with shortened soft-start and lockout.
module tb_loop_stepdown_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] duty = 8'd0;
    logic       ocp = 1'b0;
    logic       zcd = 1'b0;
    logic       hs_on, ls_on, ss_done, fault;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    loop_stepdown_seq #(.DT(4), .SS_DIV(2), .FAULT_HOLD(20)) dut (
        .clk(clk), .rst(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
        .en(en), .duty(duty), .ocp(ocp), .zcd(zcd),
        .hs_on(hs_on), .ls_on(ls_on), .ss_done(ss_done), .fault(fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Output observed after edge k reflects cnt = (k-1) mod 256 relative to SOFTSTART entry.
    task automatic run_period(input int d, input int zat, input int chg_at, input int chg_val);
        logic exp_hs, exp_ls;
        while (cyc % 256 != 0) step();
        for (int i = 0; i < 256; i++) begin
            step();
            exp_hs = (i >= 4) && (i < d);
            exp_ls = (i >= d + 4) && !(zat >= 0 && i >= zat);
            checks++;
            if (hs_on !== exp_hs) begin
                errors++;
                $display("FAIL hs_on d=%0d c=%0d got %b want %b", d, i, hs_on, exp_hs);
            end
            checks++;
            if (ls_on !== exp_ls) begin
                errors++;
                $display("FAIL ls_on d=%0d c=%0d got %b want %b", d, i, ls_on, exp_ls);
            end
            if (i == zat - 1) zcd = 1'b1;
            if (i == zat) zcd = 1'b0;
            if (i == chg_at) duty = 8'(chg_val);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({hs_on, ls_on, ss_done, fault} !== 4'b0000) begin
            errors++;
            $display("FAIL %s hs/ls/ss/fault got %b%b%b%b want 0000", name, hs_on, ls_on, ss_done, fault);
        end
    endtask

    task automatic check_ss(input string name, input logic want);
        checks++;
        if (ss_done !== want) begin
            errors++;
            $display("FAIL %s ss_done got %b want %b", name, ss_done, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; ocp = 1'b1; zcd = 1'b1; duty = 8'd8;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all_zero("reset");
        end
    endtask

    task automatic test_softstart();
        rst = 1'b0; ocp = 1'b0; zcd = 1'b0; en = 1'b1; duty = 8'd8;
        step();
        cyc = 0;
        while (cyc < 3072) step();
        run_period(6, -1, -1, 0);
        while (cyc < 4095) step();
        check_ss("ss_before_done", 1'b0);
        step();
        check_ss("ss_done_set", 1'b1);
        run_period(8, -1, -1, 0);
    endtask

    task automatic test_run_duty();
        duty = 8'd100; run_period(8, -1, -1, 0);   run_period(100, -1, -1, 0);
        duty = 8'd255; run_period(100, -1, -1, 0); run_period(255, -1, -1, 0);
        duty = 8'd0;   run_period(255, -1, -1, 0); run_period(0, -1, -1, 0);
        duty = 8'd2;   run_period(0, -1, -1, 0);   run_period(2, -1, -1, 0);
        duty = 8'd100; run_period(2, -1, -1, 0);   run_period(100, -1, -1, 0);
    endtask

    task automatic test_duty_step();
        run_period(100, -1, 29, 20);
        run_period(20, -1, -1, 0);
    endtask

    task automatic test_zcd();
        duty = 8'd100;
        run_period(20, -1, -1, 0);
        run_period(100, 180, -1, 0);
        run_period(100, -1, -1, 0);
    endtask

    task automatic test_ocp();
        while (cyc % 256 != 0) step();
        for (int i = 0; i < 50; i++) step();
        ocp = 1'b1;
        step();
        checks++;
        if (hs_on !== 1'b0 || fault !== 1'b1) begin
            errors++;
            $display("FAIL ocp_entry hs/fault got %b/%b want 0/1", hs_on, fault);
        end
        ocp = 1'b0; duty = 8'd1;
        for (int j = 2; j <= 20; j++) begin
            step();
            checks++;
            if (fault !== 1'b1 || hs_on !== 1'b0 || ls_on !== 1'b0) begin
                errors++;
                $display("FAIL ocp_hold n=%0d fault/hs/ls got %b/%b/%b want 1/0/0", j, fault, hs_on, ls_on);
            end
        end
        step();
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL ocp_release fault got %b want 0", fault);
        end
        cyc = 0;
        run_period(0, -1, -1, 0);
        check_ss("ss_after_fault", 1'b0);
        while (cyc < 511) step();
        check_ss("ss_duty1_pre", 1'b0);
        step();
        check_ss("ss_duty1_done", 1'b1);
    endtask

    task automatic test_en_drop();
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (ls_on !== 1'b1) begin
            errors++;
            $display("FAIL ls_before_drop got %b want 1", ls_on);
        end
        en = 1'b0;
        step();
        check_all_zero("en_drop");
        en = 1'b1;
        step();
        for (int i = 0; i < 10; i++) step();
        en = 1'b0; ocp = 1'b1;
        step();
        checks++;
        if (fault !== 1'b1 || hs_on !== 1'b0 || ls_on !== 1'b0) begin
            errors++;
            $display("FAIL ocp_priority fault/hs/ls got %b/%b/%b want 1/0/0", fault, hs_on, ls_on);
        end
        en = 1'b1;
    endtask

    task automatic test_reset_fault();
        for (int i = 0; i < 25; i++) step();
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_retrigger fault got %b want 1", fault);
        end
        rst = 1'b1;
        step();
        check_all_zero("reset_in_fault");
        rst = 1'b0; ocp = 1'b0; en = 1'b1; duty = 8'd0;
        step();
        cyc = 0;
        run_period(0, -1, -1, 0);
        while (cyc < 511) step();
        check_ss("ss_duty0_pre", 1'b0);
        step();
        check_ss("ss_duty0_done", 1'b1);
    endtask

    task automatic test_reset_run();
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (ls_on !== 1'b1) begin
            errors++;
            $display("FAIL ls_before_reset got %b want 1", ls_on);
        end
        rst = 1'b1;
        step();
        check_all_zero("reset_in_run");
        rst = 1'b0;
        step();
        cyc = 0;
        run_period(0, -1, -1, 0);
        check_ss("ss_after_reset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_softstart();
        test_run_duty();
        test_duty_step();
        test_zcd();
        test_ocp();
        test_en_drop();
        test_reset_fault();
        test_reset_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
